// File: rtl/nios2_system_sysid_pkg.sv
// Shared types and constants for the sysid checker slice.
package nios2_system_sysid_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ID_WAIT = 2'd1,
    S_TS_WAIT = 2'd2,
    S_DONE    = 2'd3
  } sysid_state_e;

  localparam logic        SYSID_ADDR_ID      = 1'b0;
  localparam logic        SYSID_ADDR_TS      = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_ID   = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TS   = 32'd1619608944;

  // Full-width compare of a captured ID/timestamp pair against expectations.
  function automatic logic sysid_match(input logic [31:0] id, input logic [31:0] ts,
                                       input logic [31:0] exp_id, input logic [31:0] exp_ts);
    return (id == exp_id) && (ts == exp_ts);
  endfunction

endpackage

// File: rtl/nios2_system_sysid_checker_if.sv
// Sysid control_slave read port: one address bit, 32-bit readdata.
interface nios2_system_sysid_checker_if;
  logic        sysid_address;
  logic [31:0] sysid_readdata;

  modport master (output sysid_address, input sysid_readdata);
  modport slave  (input sysid_address, output sysid_readdata);
endinterface

// File: rtl/nios2_system_sysid_chk_timer.sv
// Period counter for automatic rechecks: counts cycles while run is high and
// pulses expire on the PERIOD-th cycle, then restarts from zero.
module nios2_system_sysid_chk_timer #(
  parameter int PERIOD = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic expire
);

  localparam logic [19:0] LAST = 20'(PERIOD - 1);

  logic [19:0] cnt_q;

  assign expire = run && (cnt_q == LAST);

  // Counter is held at zero whenever the checker is not sitting in DONE.
  always_ff @(posedge clock) begin
    if (!reset_n || !run || expire) cnt_q <= '0;
    else                            cnt_q <= cnt_q + 20'd1;
  end

endmodule

// File: rtl/nios2_system_sysid_checker.sv
// Reads sysid address 0 (ID) then address 1 (timestamp), holding each address
// WAIT_CYCLES extra cycles before sampling, and flags a mismatch against the
// expected values. Optional macro SYSID_CHK_PERIODIC_EN adds automatic
// rechecks every PERIOD cycles spent in DONE.
module nios2_system_sysid_checker
  import nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
  parameter int          WAIT_CYCLES        = 1,
  parameter int          PERIOD             = 1024
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 start,
  nios2_system_sysid_checker_if.master         sysid,
  output logic [31:0]                          id_value,
  output logic [31:0]                          ts_value,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 match,
  output logic                                 error_sticky
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES out of range 0..15");
  end
  if (PERIOD < 2 || PERIOD > (1 << 20)) begin : g_bad_period
    $error("PERIOD out of range 2..2^20");
  end

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  sysid_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         addr_q;
  logic [31:0]  id_q, ts_q;
  logic         match_q, err_q;
  logic         cap_id, cap_ts;
  logic         self_start;

`ifdef SYSID_CHK_PERIODIC_EN
  nios2_system_sysid_chk_timer #(.PERIOD(PERIOD)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (state_q == S_DONE),
    .expire  (self_start)
  );
`else
  assign self_start = 1'b0;
`endif

  // Next-state decode and capture strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ID_WAIT;
          cnt_d   = '0;
        end
      end
      S_ID_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cap_id  = 1'b1;
          cnt_d   = '0;
          state_d = S_TS_WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_TS_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cap_ts  = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (start || self_start) begin
          state_d = S_ID_WAIT;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered address, captured values and status flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= SYSID_ADDR_ID;
      id_q    <= '0;
      ts_q    <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= (state_d == S_TS_WAIT) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      if (cap_id) id_q <= sysid.sysid_readdata;
      if (cap_ts) begin
        // ID was captured on an earlier edge; timestamp is compared as it lands.
        ts_q    <= sysid.sysid_readdata;
        match_q <= sysid_match(id_q, sysid.sysid_readdata, EXPECTED_ID, EXPECTED_TIMESTAMP);
        if (!sysid_match(id_q, sysid.sysid_readdata, EXPECTED_ID, EXPECTED_TIMESTAMP))
          err_q <= 1'b1;
      end else if (state_d != S_DONE) begin
        match_q <= 1'b0;
      end
    end
  end

  assign sysid.sysid_address = addr_q;
  assign id_value            = id_q;
  assign ts_value            = ts_q;
  assign busy                = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
  assign done                = (state_q == S_DONE);
  assign match               = match_q;
  assign error_sticky        = err_q;

endmodule

// File: tb/tb_nios2_system_sysid_checker.sv
// Scoreboard bench for the sysid checker: three instances (WAIT_CYCLES 1, 0, 15)
// share a sysid model; a monitor pops expectations on each rising done.
module tb_nios2_system_sysid_checker;

  localparam logic [31:0] TS_OK = 32'd1619608944;

  typedef struct {
    int          dut;
    logic [31:0] id;
    logic [31:0] ts;
    logic        m;
    logic        e;
    int          lat;
    int          scyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  start = 3'b000;
  logic [31:0] id_m = 32'd0;
  logic [31:0] ts_m = TS_OK;
  logic [2:0]  addr, busy, done, match, err;
  logic [31:0] idv [3];
  logic [31:0] tsv [3];
  logic [2:0]  done_prev = 3'b000;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nios2_system_sysid_checker_if bus ();
    assign bus.sysid_readdata = bus.sysid_address ? ts_m : id_m;
    assign addr[g] = bus.sysid_address;
    nios2_system_sysid_checker #(
      .EXPECTED_ID        (32'd0),
      .EXPECTED_TIMESTAMP (TS_OK),
      .WAIT_CYCLES        ((g == 0) ? 1 : (g == 1) ? 0 : 15),
      .PERIOD             ((g == 0) ? 8 : 1024)
    ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start[g]),
      .sysid        (bus.master),
      .id_value     (idv[g]),
      .ts_value     (tsv[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .match        (match[g]),
      .error_sticky (err[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: compares each rising done against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (done[d] && !done_prev[d]) begin
        if (sb.size() > 0 && sb[0].dut == d) begin
          e = sb.pop_front();
          chk($sformatf("dut%0d_id", d), idv[d], e.id);
          chk($sformatf("dut%0d_ts", d), tsv[d], e.ts);
          chk($sformatf("dut%0d_match", d), {31'd0, match[d]}, {31'd0, e.m});
          chk($sformatf("dut%0d_err", d), {31'd0, err[d]}, {31'd0, e.e});
          chk($sformatf("dut%0d_latency", d), 32'(cyc - e.scyc), 32'(e.lat));
        end else begin
`ifndef SYSID_CHK_PERIODIC_EN
          n_cmp++;
          n_bad++;
          $display("FAIL dut%0d_unexpected_done: got done=1 required no done", d);
`endif
        end
      end
      done_prev[d] = done[d];
    end
  end

  // One check on instance d; optionally traces address/busy and holds start while busy.
  task automatic run_check(input int d, input logic [31:0] mid, input logic [31:0] mts,
                           input logic em, input logic ee, input int lat,
                           input bit trace, input bit hold);
    exp_t e;
    int   k;
    int   w;
    w = (d == 0) ? 1 : (d == 1) ? 0 : 15;
    @(negedge clock);
    id_m = mid;
    ts_m = mts;
    e.dut = d; e.id = mid; e.ts = mts; e.m = em; e.e = ee; e.lat = lat; e.scyc = cyc + 1;
    sb.push_back(e);
    start[d] = 1'b1;
    @(negedge clock);
    start[d] = 1'b0;
    chk($sformatf("dut%0d_busy_first", d), {31'd0, busy[d]}, 32'd1);
    chk($sformatf("dut%0d_match_cleared", d), {31'd0, match[d]}, 32'd0);
    k = 1;
    while (!done[d] && k <= 200) begin
      if (trace) begin
        chk($sformatf("dut%0d_addr_k%0d", d, k), {31'd0, addr[d]}, (k <= w + 1) ? 32'd0 : 32'd1);
        chk($sformatf("dut%0d_busy_k%0d", d, k), {31'd0, busy[d]}, 32'd1);
      end
      if (hold) start[d] = (k <= 2);
      @(negedge clock);
      k++;
    end
    start[d] = 1'b0;
    if (!done[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut%0d_done_timeout: got done=0 required done=1", d);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_dut%0d_flags", tag, d),
          {27'd0, addr[d], busy[d], done[d], match[d], err[d]}, 32'd0);
      chk($sformatf("%s_dut%0d_id", tag, d), idv[d], 32'd0);
      chk($sformatf("%s_dut%0d_ts", tag, d), tsv[d], 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish before limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  held_ok;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;

    run_check(0, 32'd0, TS_OK,         1'b1, 1'b0, 4,  1'b1, 1'b0);
    run_check(0, 32'd0, 32'hDEADBEEF,  1'b0, 1'b1, 4,  1'b0, 1'b0);
    run_check(0, 32'd0, TS_OK,         1'b1, 1'b1, 4,  1'b0, 1'b1);
    run_check(0, 32'd5, TS_OK,         1'b0, 1'b1, 4,  1'b0, 1'b0);
    run_check(1, 32'd0, TS_OK,         1'b1, 1'b0, 2,  1'b1, 1'b0);
    run_check(2, 32'd0, TS_OK,         1'b1, 1'b0, 32, 1'b1, 1'b0);
    run_check(1, 32'd0, TS_OK ^ 32'd1, 1'b0, 1'b1, 2,  1'b0, 1'b0);
    @(negedge clock);

    // Abort in TS_WAIT: no expectation queued, everything must return to zero.
    id_m = 32'd0;
    ts_m = 32'hDEADBEEF;
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_in_ts_wait_addr", {31'd0, addr[0]}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk_all_zero("abort");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("no_restart_after_reset", {29'd0, busy | done}, 32'd0);

    run_check(0, 32'd0, TS_OK, 1'b1, 1'b0, 4, 1'b0, 1'b0);
`ifdef SYSID_CHK_PERIODIC_EN
    n = 0;
    while (!busy[0] && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("periodic_restart_gap", 32'(n), 32'd8);
`else
    held_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!done[0] || busy[0] || !match[0]) held_ok = 1'b0;
    end
    chk("done_held_100", {31'd0, held_ok}, 32'd1);
`endif
    repeat (2) @(negedge clock);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios2_system_sysid_checker.md
NIOS2_SYSTEM_SYSID_CHECKER -- requirements
Module: nios2_system_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0, system ID value expected at sysid address 0.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'd1619608944, value expected at sysid address 1.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, extra cycles address is held before readdata is sampled.
REQ-004 SHALL have parameter PERIOD, default 1024, range 2..2^20, cycles between automatic rechecks (macro-gated, REQ-026).
REQ-005 SHALL use one clock and a synchronous, active-low reset: clock and reset_n.
REQ-006 Ports: clock  in  1  system clock, rising edge only.
REQ-007 Ports: reset_n  in  1  synchronous active-low reset.
REQ-008 Ports: start  in  1  request one check, sampled only in IDLE or DONE.
REQ-009 Ports: sysid_address  out  1  drives the sysid control_slave address.
REQ-010 Ports: sysid_readdata  in  32  sysid control_slave readdata.
REQ-011 Ports: id_value, ts_value  out  32 each  captured ID and timestamp.
REQ-012 Ports: busy, done, match, error_sticky  out  1 each  status flags.

Function
REQ-013 SHALL implement FSM states IDLE, ID_WAIT, TS_WAIT, DONE.
REQ-014 IDLE/DONE + start=1 -> ID_WAIT with wait counter cleared; start ignored in ID_WAIT/TS_WAIT.
REQ-015 ID_WAIT: sysid_address=0; counter increments each cycle; when counter==WAIT_CYCLES, id_value<=sysid_readdata, counter cleared, -> TS_WAIT.
REQ-016 TS_WAIT: sysid_address=1; when counter==WAIT_CYCLES, ts_value<=sysid_readdata, -> DONE.
REQ-017 sysid_address SHALL be registered (state-decoded, glitch-free); 0 in IDLE and DONE.
REQ-018 busy=1 exactly in ID_WAIT and TS_WAIT; done=1 exactly in DONE (level, held until next start).
REQ-019 Latency: done SHALL first read 1 after the 2*(WAIT_CYCLES+1)-th rising edge following the edge that sampled start.
REQ-020 match SHALL be registered on DONE entry: 1 iff captured id==EXPECTED_ID and ts==EXPECTED_TIMESTAMP (full 32-bit compare); held until next DONE entry; 0 when not done.
REQ-021 error_sticky SHALL set on any DONE entry with match=0, cleared only by reset.
REQ-022 id_value/ts_value SHALL hold last captured values between checks; a restart overwrites them in order.
REQ-023 Wait counter 4 bits; WAIT_CYCLES=0 SHALL give one-cycle sampling per address, no wrap.

Reset
REQ-024 reset_n=0 at a rising edge SHALL force IDLE, counters 0, sysid_address=0, id_value=ts_value=0, busy=done=match=error_sticky=0.
REQ-025 Reset mid-check SHALL abort without updating match or error_sticky; no automatic restart after reset release.

Configuration
REQ-026 Macro SYSID_CHK_PERIODIC_EN defined: a 20-bit period counter runs in DONE, and after PERIOD cycles in DONE the FSM SHALL self-start (as if start=1), clearing the counter; explicit start in DONE restarts immediately and clears it.
REQ-027 Macro undefined: no period counter logic; DONE left only via start or reset.

Structure
REQ-028 Shared package nios2_system_sysid_pkg SHALL hold the state enum type, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1 and default expected constants.
REQ-029 Sub-module nios2_system_sysid_chk_timer SHALL implement the period counter, instantiated only under SYSID_CHK_PERIODIC_EN; wait counter stays inline.

Verification
REQ-030 Model sysid (addr0->0, addr1->1619608944), WAIT_CYCLES=1, pulse start -> done after 4th edge, id_value=0, ts_value=1619608944, match=1, error_sticky=0.
REQ-031 Model returns 0xDEADBEEF at addr1 -> match=0, error_sticky=1; rerun with correct model -> match=1, error_sticky stays 1.
REQ-032 WAIT_CYCLES=0 and 15 -> done after 2 and 32 edges respectively; sysid_address 0 for 1/16 cycles then 1 for 1/16 cycles.
REQ-033 reset_n=0 during TS_WAIT -> next cycle all outputs 0, state IDLE; start held during busy has no effect.
REQ-034 SYSID_CHK_PERIODIC_EN, PERIOD=8 -> busy reasserts 8 cycles after done; undefined -> done held 100 cycles without restart.
